// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding and the "no source" claim ID.
package irq_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_MASK     = 3'd1;
  localparam logic [2:0] REG_MODE     = 3'd2;
  localparam logic [2:0] REG_PENDING  = 3'd3;
  localparam logic [2:0] REG_CLAIM    = 3'd4;
  localparam logic [2:0] REG_COMPLETE = 3'd5;

  localparam logic [2:0] ID_NONE = 3'd0;

  // HWInt into CP0 is always 6 bits wide, whatever NSRC is.
  localparam int HWINT_W = 6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder. The ID is the source index plus one,
// so that 0 can mean "nothing requested".
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NSRC = 6
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = ID_NONE;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches peripheral IRQ lines (edge or
// level per source), masks them, claims the lowest-index eligible source and
// holds a registered request to CP0 until the CPU retires it via COMPLETE.
// NSRC must lie in 1..6.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:2]        Addr,
  input  logic               WE,
  input  logic [31:0]        Din,
  output logic [31:0]        Dout,
  input  logic [NSRC-1:0]    irq_in,
  output logic [HWINT_W-1:0] HWInt,
  output logic               irq_out
);

  logic            ge;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] edge_set;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] cmp_clr;
  logic [2:0]      off;
  logic [2:0]      claim_id;
  logic [2:0]      claim_next;
  logic            irq_next;
  logic            wr_ctrl;
  logic            wr_pending;
  logic            wr_complete;
  logic            complete_hit;
  logic            ge_drop;
  logic            enc_valid;
  logic [2:0]      enc_id;
  logic            unused_bits;
  state_t          state;
  state_t          state_next;

  assign off         = Addr[4:2];
  assign wr_ctrl     = WE && (off == REG_CTRL);
  assign wr_pending  = WE && (off == REG_PENDING);
  assign wr_complete = WE && (off == REG_COMPLETE);

  assign eligible = pending & mask & {NSRC{ge}};
  assign HWInt    = HWINT_W'(eligible);

  // Only the claimed ID retires the interrupt; a disable of GE is the other way out.
  assign complete_hit = (state == S_BUSY) && wr_complete && (Din[2:0] == claim_id);
  assign ge_drop      = (state == S_BUSY) && wr_ctrl && !Din[0];

  assign edge_set = irq_in & ~irq_q;
  assign w1c      = wr_pending ? Din[NSRC-1:0] : '0;

  // Upper address bits and unused data bits are deliberately ignored.
  assign unused_bits = ^{Addr[31:5], Din};

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // Per-source clear from a matching COMPLETE; edge sources only ever see it.
  always_comb begin
    cmp_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      cmp_clr[i] = complete_hit && (claim_id == 3'(i + 1));
    end
  end

  // Edge sources: set beats clear. Level sources simply follow the input.
  always_comb begin
    pending_next = (mode & (edge_set | (pending & ~(w1c | cmp_clr)))) | (~mode & irq_in);
  end

  // Input history and pending latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= pending_next;
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ge   <= 1'b0;
      mask <= '0;
      mode <= '0;
    end else if (WE) begin
      case (off)
        REG_CTRL: ge   <= Din[0];
        REG_MASK: mask <= Din[NSRC-1:0];
        REG_MODE: mode <= Din[NSRC-1:0];
        default:  ;
      endcase
    end
  end

  // Claim FSM state register, including the registered request to CP0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      claim_id <= ID_NONE;
      irq_out  <= 1'b0;
    end else begin
      state    <= state_next;
      claim_id <= claim_next;
      irq_out  <= irq_next;
    end
  end

  // Claim FSM next state: claim in IDLE, hold in BUSY until GE drop or COMPLETE.
  always_comb begin
    state_next = state;
    claim_next = claim_id;
    irq_next   = irq_out;
    case (state)
      S_IDLE: begin
        if (enc_valid) begin
          claim_next = enc_id;
          irq_next   = 1'b1;
          state_next = S_BUSY;
        end else begin
          irq_next = 1'b0;
        end
      end
      S_BUSY: begin
        irq_next = 1'b1;
        if (ge_drop || complete_hit) begin
          irq_next   = 1'b0;
          claim_next = ID_NONE;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        claim_next = ID_NONE;
        irq_next   = 1'b0;
      end
    endcase
  end

  // Combinational read mux.
  always_comb begin
    Dout = '0;
    case (off)
      REG_CTRL:    Dout = {31'b0, ge};
      REG_MASK:    Dout = 32'(mask);
      REG_MODE:    Dout = 32'(mode);
      REG_PENDING: Dout = 32'(pending);
      REG_CLAIM:   Dout = {29'b0, claim_id};
      default:     Dout = '0;
    endcase
  end

endmodule
